// File: rtl/posit_pkg.sv
// posit_pkg
//   Shared constants and types for the posit field-decode arbiter.
//   N, ES      : default posit width and exponent field width.
//   RW, MW     : regime width ($clog2(N)+1, signed) and mantissa width
//                (hidden bit plus fraction, N-ES-2).
//   rr_state_t : round-robin pointer (which requester wins a tie).
//   posit_fields_t : decoded {sign, regime, exp, mant}.
// The struct widths follow the package N/ES, so a different posit format
// is selected by editing the defaults here rather than overriding module
// parameters alone.
package posit_pkg;

    localparam int N  = 8;
    localparam int ES = 3;
    localparam int RW = $clog2(N) + 1;
    localparam int MW = N - ES - 2;

    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_state_t;

    typedef struct packed {
        logic                 sign;
        logic signed [RW-1:0] regime;
        logic [ES-1:0]        exp;
        logic [MW-1:0]        mant;
    } posit_fields_t;

endpackage

// File: rtl/posit_field_decode.sv
// posit_field_decode
//   Purely combinational posit field extraction.
//   posit  (in,  N)              : raw posit word.
//   fields (out, posit_fields_t) : sign (original MSB), signed regime k,
//                                  exponent (zero-padded when truncated),
//                                  mantissa {1, fraction left-aligned}.
//   Zero and NaR decode to all-zero fields.
module posit_field_decode #(
    parameter int N  = posit_pkg::N,
    parameter int ES = posit_pkg::ES
) (
    input  logic [N-1:0]             posit,
    output posit_pkg::posit_fields_t fields
);
    import posit_pkg::*;

    localparam int BW = N - 1;          // bits after the sign
    localparam int FW = N - ES - 3;     // max fraction bits
    localparam int CW = $clog2(N) + 1;  // run length / regime width

    logic [BW-1:0] mag;
    logic          lead;
    logic [BW-1:0] in_run;
    logic [CW-1:0] run_len;
    logic [CW-1:0] k_bits;
    logic [BW-1:0] tail;
    logic          special;

    // Only the bits below the sign are needed after negation; the low N-1
    // bits of the two's complement equal the negation of those bits.
    assign mag     = posit[N-1] ? (~posit[N-2:0] + 1'b1) : posit[N-2:0];
    assign lead    = mag[BW-1];
    assign special = (posit[N-2:0] == '0);

    // in_run[gi] is set when every bit from the top down to gi matches the
    // leading regime bit, so the run length is the population count.
    generate
        for (genvar gi = 0; gi < BW; gi++) begin : g_run
            assign in_run[gi] = (mag[BW-1:gi] == {(BW-gi){lead}});
        end
    endgenerate

    always_comb begin
        run_len = '0;
        for (int i = 0; i < BW; i++) begin
            run_len = run_len + CW'(in_run[i]);
        end
    end

    // Drop the regime run and its terminator; a run reaching the LSB shifts
    // everything out, which leaves exponent and fraction zero-padded.
    assign tail   = mag << (run_len + CW'(1));
    assign k_bits = lead ? (run_len - CW'(1)) : (CW'(0) - run_len);

    always_comb begin
        fields = '0;
        if (!special) begin
            fields.sign   = posit[N-1];
            fields.regime = k_bits;
            fields.exp    = tail[BW-1 -: ES];
            fields.mant   = {1'b1, tail[BW-1-ES -: FW]};
        end
    end

endmodule

// File: rtl/posit_extract_arbiter.sv
// posit_extract_arbiter
//   Two-requester round-robin arbiter feeding a 2-stage posit decode pipe.
//   clk, reset            : clock, synchronous active-high reset.
//   a_valid/a_ready/a_posit : requester A handshake and posit.
//   b_valid/b_ready/b_posit : requester B handshake and posit.
//   out_valid/out_ready     : result handshake.
//   out_src                 : 0 = A, 1 = B.
//   out_sign, out_regime, out_exp, out_mant : decoded fields.
//   Optional POSIT_SPECIAL_FLAG_EN adds out_zero / out_nar flags.
//   S1 holds the captured posit, the decoder sits between S1 and S2, and S2
//   is the output register.
module posit_extract_arbiter #(
    parameter int N  = posit_pkg::N,
    parameter int ES = posit_pkg::ES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [N-1:0]         a_posit,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [N-1:0]         b_posit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_src,
    output logic                 out_sign,
    output logic [$clog2(N):0]   out_regime,
    output logic [ES-1:0]        out_exp,
    output logic [N-ES-3:0]      out_mant
`ifdef POSIT_SPECIAL_FLAG_EN
    ,
    output logic                 out_zero,
    output logic                 out_nar
`endif
);
    import posit_pkg::*;

    rr_state_t     rr_reg, rr_next;
    logic          s1_valid_reg;
    logic          s1_src_reg;
    logic [N-1:0]  s1_posit_reg;
    logic          s2_valid_reg;
    logic          s2_src_reg;
    posit_fields_t s2_fields_reg;
    posit_fields_t dec_fields;

    logic s2_free;
    logic s1_free;
    logic take_a;
    logic take_b;
    logic xfer;

    // A stage can load when it is empty or its content moves on this cycle.
    assign s2_free = !s2_valid_reg || out_ready;
    assign s1_free = !s1_valid_reg || s2_free;

    // Arbitration and readies: a pure function of valids, pointer and
    // occupancy, never of the posit data.
    always_comb begin
        take_a  = 1'b0;
        take_b  = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        rr_next = rr_reg;
        if (!reset && s1_free) begin
            a_ready = a_valid && (!b_valid || rr_reg == RR_A);
            b_ready = b_valid && (!a_valid || rr_reg == RR_B);
            take_a  = a_ready;
            take_b  = b_ready;
        end
        // Pointer moves to the requester that lost this transfer.
        if (take_a) begin
            rr_next = RR_B;
        end else if (take_b) begin
            rr_next = RR_A;
        end
    end

    assign xfer = take_a || take_b;

    posit_field_decode #(
        .N  (N),
        .ES (ES)
    ) u_decode (
        .posit  (s1_posit_reg),
        .fields (dec_fields)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_reg        <= RR_A;
            s1_valid_reg  <= 1'b0;
            s1_src_reg    <= 1'b0;
            s1_posit_reg  <= '0;
            s2_valid_reg  <= 1'b0;
            s2_src_reg    <= 1'b0;
            s2_fields_reg <= '0;
        end else begin
            rr_reg <= rr_next;
            if (s1_free) begin
                s1_valid_reg <= xfer;
                if (xfer) begin
                    s1_posit_reg <= take_b ? b_posit : a_posit;
                    s1_src_reg   <= take_b;
                end
            end
            if (s2_free) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_fields_reg <= dec_fields;
                    s2_src_reg    <= s1_src_reg;
                end
            end
        end
    end

    assign out_valid  = s2_valid_reg;
    assign out_src    = s2_src_reg;
    assign out_sign   = s2_fields_reg.sign;
    assign out_regime = s2_fields_reg.regime;
    assign out_exp    = s2_fields_reg.exp;
    assign out_mant   = s2_fields_reg.mant;

`ifdef POSIT_SPECIAL_FLAG_EN
    logic zero_reg;
    logic nar_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_reg <= 1'b0;
            nar_reg  <= 1'b0;
        end else if (s2_free && s1_valid_reg) begin
            zero_reg <= (s1_posit_reg == '0);
            nar_reg  <= (s1_posit_reg == {1'b1, {(N-1){1'b0}}});
        end
    end

    assign out_zero = zero_reg;
    assign out_nar  = nar_reg;
`endif

endmodule

// File: tb/tb_posit_extract_arbiter.sv
// tb_posit_extract_arbiter
//   Table-driven decode vectors, directed multi-cycle sequences (reset,
//   latency, alternation, stall, mid-operation reset) and a randomized
//   phase scored against an arithmetic reference model.
module tb_posit_extract_arbiter;
    localparam int N  = 8;
    localparam int ES = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
    logic [N-1:0] a_posit = '0, b_posit = '0;
    logic         a_ready, b_ready, out_valid, out_src, out_sign;
    logic [$clog2(N):0] out_regime;
    logic [ES-1:0]      out_exp;
    logic [N-ES-3:0]    out_mant;
`ifdef POSIT_SPECIAL_FLAG_EN
    logic out_zero, out_nar;
`endif

    posit_extract_arbiter #(.N(N), .ES(ES)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_posit(a_posit),
        .b_valid(b_valid), .b_ready(b_ready), .b_posit(b_posit),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
        .out_sign(out_sign), .out_regime(out_regime), .out_exp(out_exp),
        .out_mant(out_mant)
`ifdef POSIT_SPECIAL_FLAG_EN
        , .out_zero(out_zero), .out_nar(out_nar)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int sign; int k; int e; int m; int zero; int nar;
    } dec_t;

    // Reference decode: walks the bit string of the magnitude one position
    // at a time, as the posit definition reads it.
    function automatic dec_t ref_decode(input logic [N-1:0] p);
        dec_t d;
        int val, pos, run, first, bitv;
        d = '{default: 0};
        val = int'(p);
        if (val == 0) begin d.zero = 1; return d; end
        if (val == (1 << (N-1))) begin d.nar = 1; return d; end
        d.sign = val >> (N-1);
        if (d.sign != 0) val = (1 << N) - val;
        pos = N - 2;
        first = (val >> pos) & 1;
        run = 0;
        while (pos >= 0 && ((val >> pos) & 1) == first) begin
            run++;
            pos--;
        end
        d.k = (first != 0) ? run - 1 : -run;
        pos--;  // terminating bit (no-op effect if the run hit the end)
        for (int i = 0; i < ES; i++) begin
            bitv = (pos >= 0) ? ((val >> pos) & 1) : 0;
            d.e = d.e * 2 + bitv;
            pos--;
        end
        d.m = 1;
        for (int i = 0; i < N - ES - 3; i++) begin
            bitv = (pos >= 0) ? ((val >> pos) & 1) : 0;
            d.m = d.m * 2 + bitv;
            pos--;
        end
        return d;
    endfunction

    task automatic check_fields(input string tag, input int src, input dec_t d);
        check({tag, "_src"},    int'(out_src), src);
        check({tag, "_sign"},   int'(out_sign), d.sign);
        check({tag, "_regime"}, int'($signed(out_regime)), d.k);
        check({tag, "_exp"},    int'(out_exp), d.e);
        check({tag, "_mant"},   int'(out_mant), d.m);
`ifdef POSIT_SPECIAL_FLAG_EN
        check({tag, "_zero"},   int'(out_zero), d.zero);
        check({tag, "_nar"},    int'(out_nar), d.nar);
`endif
    endtask

    // Scoreboard state: expected results in flight and the pointer model.
    typedef struct { int src; dec_t d; } exp_t;
    exp_t q[$];
    int   rr_m = 0;
    int   pushed = 0;
    int   popped = 0;

    // One cycle: evaluate at the falling edge, then step past the rising
    // edge so the caller can drive the next inputs.
    task automatic sb_cycle();
        int   can, ga, gb;
        exp_t e;
        @(negedge clk);
        // Two slots; a full pipe only takes new data when the output drains.
        can = (q.size() < 2 || out_ready) ? 1 : 0;
        ga = (can != 0 && a_valid && (!b_valid || rr_m == 0)) ? 1 : 0;
        gb = (can != 0 && b_valid && (!a_valid || rr_m == 1)) ? 1 : 0;
        check("sb_a_ready", int'(a_ready), ga);
        check("sb_b_ready", int'(b_ready), gb);
        if (q.size() == 2) check("sb_out_valid_full", int'(out_valid), 1);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("sb_unexpected_output", 1, 0);
            end else begin
                e = q.pop_front();
                popped++;
                check_fields("sb", e.src, e.d);
            end
        end
        if (a_valid && a_ready) begin
            q.push_back('{0, ref_decode(a_posit)});
            pushed++;
            rr_m = 1;
        end else if (b_valid && b_ready) begin
            q.push_back('{1, ref_decode(b_posit)});
            pushed++;
            rr_m = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(negedge clk);
        check("rst_a_ready", int'(a_ready), 0);
        check("rst_b_ready", int'(b_ready), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_fields", int'({out_src, out_sign, out_regime, out_exp, out_mant}), 0);
`ifdef POSIT_SPECIAL_FLAG_EN
        check("rst_flags", int'({out_zero, out_nar}), 0);
`endif
        q.delete();
        rr_m = 0;
    endtask

    typedef struct {
        logic [N-1:0] p;
        int sign; int k; int e; int m; int zero; int nar;
    } vec_t;

    initial begin
        vec_t tbl[12];
        dec_t d;
        int   found, cnt, xfers;
        int   srcs[$];
        logic [N-1:0] saved_payload;
        logic [N-1:0] next_p;

        // Hand-derived decode vectors.
        tbl[0]  = '{8'h50, 0,  0, 4, 4, 0, 0};  // 0_10_100_00
        tbl[1]  = '{8'h6B, 0,  1, 5, 6, 0, 0};  // 0_110_101_1
        tbl[2]  = '{8'h00, 0,  0, 0, 0, 1, 0};  // zero
        tbl[3]  = '{8'h80, 0,  0, 0, 0, 0, 1};  // NaR
        tbl[4]  = '{8'h40, 0,  0, 0, 4, 0, 0};
        tbl[5]  = '{8'h20, 0, -1, 0, 4, 0, 0};
        tbl[6]  = '{8'h7F, 0,  6, 0, 4, 0, 0};  // regime fills the word
        tbl[7]  = '{8'h01, 0, -6, 0, 4, 0, 0};  // terminator is the LSB
        tbl[8]  = '{8'hFF, 1, -6, 0, 4, 0, 0};  // negative, magnitude 0x01
        tbl[9]  = '{8'hB0, 1,  0, 4, 4, 0, 0};  // negative, magnitude 0x50
        tbl[10] = '{8'h7D, 0,  4, 4, 4, 0, 0};  // exponent truncated
        tbl[11] = '{8'h03, 0, -5, 4, 4, 0, 0};  // exponent truncated

        // Reset values.
        do_reset();

        // Simultaneous requests alternate A,B,A,B with no bubbles.
        a_posit = 8'h40;
        b_posit = 8'h20;
        a_valid = 1'b1;
        b_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) srcs.push_back(int'(out_src));
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("alt_count", srcs.size(), 8);
        foreach (srcs[i]) check($sformatf("alt_src%0d", i), srcs[i], i % 2);
        repeat (3) @(posedge clk);
        #1;

        // Table vectors through requester A, with latency check.
        do_reset();
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            a_posit = tbl[i].p;
            a_valid = 1'b1;
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), int'(a_ready), 1);
            @(posedge clk); #1;
            a_valid = 1'b0;
            found = 0;
            for (int w = 1; w <= 20; w++) begin
                @(negedge clk);
                if (out_valid) begin found = w; break; end
            end
            check($sformatf("tbl%0d_latency", i), found, 2);
            d = '{tbl[i].sign, tbl[i].k, tbl[i].e, tbl[i].m, tbl[i].zero, tbl[i].nar};
            check_fields($sformatf("tbl%0d", i), 0, d);
            @(posedge clk); #1;
        end

        // Stall: out_ready low for 4 cycles while A streams.
        do_reset();
        next_p = 8'h41;
        a_posit = next_p;
        a_valid = 1'b1;
        out_ready = 1'b0;
        pushed = 0;
        popped = 0;
        saved_payload = '0;
        for (int c = 0; c < 4; c++) begin
            xfers = pushed;
            sb_cycle();
            if (pushed != xfers) begin next_p++; a_posit = next_p; end
            if (c == 1) saved_payload = {out_sign, out_regime, out_exp, out_mant};
            if (c == 3) begin
                check("stall_a_ready", int'(a_ready), 0);
                check("stall_out_valid", int'(out_valid), 1);
                check("stall_data_stable", int'({out_sign, out_regime, out_exp, out_mant}), int'(saved_payload));
            end
        end
        check("stall_xfers", pushed, 2);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            xfers = pushed;
            sb_cycle();
            if (pushed != xfers) begin next_p++; a_posit = next_p; end
        end
        a_valid = 1'b0;
        repeat (4) sb_cycle();
        check("stall_drain_empty", q.size(), 0);
        check("stall_no_loss", popped, pushed);

        // Reset while S1 and S2 are full and the pointer sits at B.
        do_reset();
        out_ready = 1'b0;
        a_posit = 8'h50;
        a_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("midrst_full", int'(out_valid), 1);
        reset = 1'b1;
        a_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(negedge clk);
        check("midrst_a_wins", int'(a_ready), 1);
        check("midrst_b_waits", int'(b_ready), 0);
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;

        // Randomized traffic against the reference model.
        do_reset();
        pushed = 0;
        popped = 0;
        for (int c = 0; c < 3000; c++) begin
            a_valid   = ($urandom % 4) != 0;
            b_valid   = ($urandom % 4) != 0;
            a_posit   = N'($urandom);
            b_posit   = N'($urandom);
            out_ready = ($urandom % 3) != 0;
            sb_cycle();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) sb_cycle();
        check("rand_drain_empty", q.size(), 0);
        check("rand_no_loss", popped, pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/posit_extract_arbiter.md
# posit_extract_arbiter

Two-requester, round-robin arbiter and 2-stage pipeline controller that shares one posit field-decode datapath. Each requester supplies an N-bit posit over a valid/ready handshake. The block returns sign, regime, exponent and hidden-bit mantissa tagged with the source ID. It sits between the posit operand sources (load path, accumulator writeback) and the posit arithmetic units.

## Interface
- `N`, 8: posit width; N >= ES+4.
- `ES`, 3: exponent field width.
- `clk`  in  1: clock; all state on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `a_valid`  in  1: requester A has a posit.
- `a_ready`  out  1: requester A transfer accepted this cycle.
- `a_posit`  in  N: requester A posit.
- `b_valid`, `b_ready`, `b_posit`: same as A, for requester B.
- `out_valid`  out  1: decoded result available.
- `out_ready`  in  1: consumer accepts result.
- `out_src`  out  1: 0 = A, 1 = B.
- `out_sign`  out  1: posit sign.
- `out_regime`  out  $clog2(N)+1: signed regime k.
- `out_exp`  out  ES: exponent field, zero-padded if truncated.
- `out_mant`  out  N-ES-2: {hidden 1, fraction left-aligned, zero-padded}.

## Operation
- Stage 0 (arbitrate/capture):
  - Grant: if both valid, the requester indicated by the round-robin pointer `rr`; if one valid, that one.
  - Only the granted requester sees ready = stage-0 can advance.
  - A transfer (valid && ready) stores the posit and src in the S1 register.
  - After each transfer, `rr` points to the non-granted requester.
- Stage 1 (decode), combinational in sub-module:
  - Negative input is two's-complemented before field extraction; `out_sign` keeps the original MSB.
  - Regime:
    - Run of m identical bits after the sign.
    - Leading 1s give k = m-1; leading 0s give k = -m.
    - Terminating bit is consumed if present.
  - Exponent: next ES bits. Fraction: remaining bits.
  - Zero (all 0) and NaR (1 followed by 0s): sign/regime/exp/mant all 0.
- Stage 2: output register holding the decoded result.
- Flow control:
  - The pipeline advances when the downstream stage is empty or being emptied: S2 empties when `!out_valid || out_ready`.
  - No bubbles are inserted; throughput is 1 result/cycle with continuous `out_ready`.
- Arbiter states: `RR_A`, `RR_B` (the pointer). Transitions happen only on a transfer.
- `out_valid` held high with data stable until `out_ready`.

## Timing
- Reset values:
  - All outputs 0; `a_ready`/`b_ready` are 0 during reset.
  - S1/S2 valid flags 0; `rr` = `RR_A`.
- Latency: transfer at cycle t gives `out_valid` at t+2 when not stalled.
- Stall: `out_valid && !out_ready` with S1 full drops both readies low the same cycle. No data is lost or duplicated.
- Simultaneous `a_valid`/`b_valid` every cycle alternates A,B,A,B.
- Reset asserted mid-operation discards S1/S2 contents next edge and returns `rr` to A.
- `a_ready`/`b_ready` are combinational from valids, `rr` and stage occupancy; they never depend on `a_posit`/`b_posit`.

## Configuration
- `POSIT_SPECIAL_FLAG_EN` defined:
  - Adds outputs `out_zero`, `out_nar` (1 bit each, reset 0), registered alongside the S2 data.
  - Each is high exactly for the zero/NaR encodings.
- Undefined: ports absent; the special encodings still decode to all-zero fields.

## Structure
- Package `posit_pkg`:
  - Parameter defaults N, ES.
  - Width constants RW = $clog2(N)+1, MW = N-ES-2.
  - Enum `rr_state_t` {RR_A, RR_B}.
  - Struct `posit_fields_t` {sign, regime, exp, mant}.
- Sub-module `posit_field_decode`: purely combinational N-bit posit to `posit_fields_t`. The arbiter instantiates it between S1 and S2.

## Test plan
- Reset, then `a_posit`=8'b0_10_100_00 with a_valid=1 and out_ready=1. Expected after 2 cycles: src 0, sign 0, regime 0, exp 3'b100, mant 3'b100.
- `b_posit`=8'b0_110_101_1. Expected: regime +1, exp 3'b101, mant 3'b110, src 1.
- Both valid continuously, A=8'h40, B=8'h20, out_ready=1. Expected: outputs alternate src 0,1,0,1 from cycle 2, one per cycle.
- out_ready held 0 for 4 cycles with A streaming. Expected: a_ready drops after 2 transfers, out data stable; on release, no loss or duplication.
- Inputs 8'h00 and 8'h80. Expected: all fields 0; with `POSIT_SPECIAL_FLAG_EN`, out_zero and out_nar respectively high.
- Reset asserted while S1 and S2 are full. Expected: out_valid 0 next cycle, rr=A; A wins the next simultaneous request.
